shift_reg_n: RTL and testbench

- Parametrised successor to the fixed 8-bit shift register used in the multiplier datapath.
- Features:
  - configurable width;
  - four shift modes: logical right, logical left, arithmetic right, rotate right;
  - parallel load;
  - autonomous multi-shift sequencer that performs Count shifts after one Start pulse and reports Busy/Done.
- Sits in datapaths (multiplier A/B registers, serial converters) under a control FSM.

---
 rtl/shift_reg_pkg.sv | 17 +
 rtl/shift_seq_fsm.sv | 77 +++++++
 rtl/shift_reg_n.sv | 113 +++++++++++
 tb/tb_shift_reg_n.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared types for the parametrised shift register and its auto-shift sequencer.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    SHR = 2'b00,
    SHL = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_state_e;

endpackage

// File: rtl/shift_seq_fsm.sv
// Auto-shift sequencer: turns one Start pulse into Count shift strobes and
// arbitrates manual Shift_En against Load and Start.
module shift_seq_fsm
  import shift_reg_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_start,
  input  logic              i_shift_en,
  input  logic [CNT_W-1:0]  i_count,
  input  shift_mode_e       i_mode,
  output logic              o_shift,
  output shift_mode_e       o_mode,
  output logic              o_busy,
  output logic              o_done
);

  seq_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  shift_mode_e      r_mode;
  logic             r_busy;
  logic             r_done;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; later assignments in the block override defaults.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mode  <= SHR;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      if (i_load) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          RUN: begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_busy  <= 1'b1;
            end
          end
          default: begin
            // DONE behaves exactly like IDLE so sequences can run back-to-back.
            r_state <= IDLE;
            if (i_start) begin
              r_mode <= i_mode;
              if (i_count == '0) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_cnt   <= i_count;
                r_state <= RUN;
                r_busy  <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  assign o_shift = !i_load && ((r_state == RUN) || (!i_start && i_shift_en));
  assign o_mode  = (r_state == RUN) ? r_mode : i_mode;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: rtl/shift_reg_n.sv
// Parametrised shift register with four shift modes, parallel load and an
// auto-shift sequencer. Define SHIFT_REG_XBIT_EN to add the X extension bit.
module shift_reg_n
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Load,
  input  logic [WIDTH-1:0]  D,
  input  shift_mode_e       Mode,
  input  logic              Shift_En,
  input  logic              Shift_In_Msb,
  input  logic              Shift_In_Lsb,
  input  logic              Start,
  input  logic [CNT_W-1:0]  Count,
`ifdef SHIFT_REG_XBIT_EN
  input  logic              X_In,
  input  logic              X_Load,
  output logic              X_Out,
`endif
  output logic [WIDTH-1:0]  Data_Out,
  output logic              Shift_Out_Msb,
  output logic              Shift_Out_Lsb,
  output logic              Busy,
  output logic              Done
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_shifted;
  logic             w_shift;
  shift_mode_e      w_mode;
`ifdef SHIFT_REG_XBIT_EN
  logic             r_x;
  logic             w_x_next;
`endif

  shift_seq_fsm #(
    .CNT_W (CNT_W)
  ) u_seq (
    .i_clk      (Clk),
    .i_rst_n    (Reset_n),
    .i_load     (Load),
    .i_start    (Start),
    .i_shift_en (Shift_En),
    .i_count    (Count),
    .i_mode     (Mode),
    .o_shift    (w_shift),
    .o_mode     (w_mode),
    .o_busy     (Busy),
    .o_done     (Done)
  );

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_shifted = r_data;
    case (w_mode)
      SHR:     w_shifted = {Shift_In_Msb, r_data[WIDTH-1:1]};
      SHL:     w_shifted = {r_data[WIDTH-2:0], Shift_In_Lsb};
      ASR:     w_shifted = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
      ROR:     w_shifted = {r_data[0], r_data[WIDTH-1:1]};
      default: w_shifted = r_data;
    endcase
`ifdef SHIFT_REG_XBIT_EN
    // X sits above the MSB, so every right shift feeds the MSB from X.
    w_x_next = r_x;
    case (w_mode)
      SHR: begin
        w_shifted[WIDTH-1] = r_x;
        w_x_next           = Shift_In_Msb;
      end
      SHL:     w_x_next           = r_data[WIDTH-1];
      ASR:     w_shifted[WIDTH-1] = r_x;
      ROR: begin
        w_shifted[WIDTH-1] = r_x;
        w_x_next           = r_data[0];
      end
      default: w_x_next           = r_x;
    endcase
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_data <= '0;
    end else if (Load) begin
      r_data <= D;
    end else if (w_shift) begin
      r_data <= w_shifted;
    end
  end

`ifdef SHIFT_REG_XBIT_EN
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_x <= 1'b0;
    end else if (X_Load) begin
      r_x <= X_In;
    end else if (w_shift) begin
      r_x <= w_x_next;
    end
  end

  assign X_Out = r_x;
`endif

  assign Data_Out      = r_data;
  assign Shift_Out_Msb = r_data[WIDTH-1];
  assign Shift_Out_Lsb = r_data[0];

endmodule

// File: tb/tb_shift_reg_n.sv
// Self-checking bench for shift_reg_n: directed steps, expected values queued
// on a scoreboard and compared one edge later.
module tb_shift_reg_n;
  import shift_reg_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef struct {
    string      tag;
    logic [7:0] data;
    logic       busy;
    logic       done;
  } exp_t;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             Load;
  logic [WIDTH-1:0] D;
  shift_mode_e      Mode;
  logic             Shift_En;
  logic             Shift_In_Msb;
  logic             Shift_In_Lsb;
  logic             Start;
  logic [CNT_W-1:0] Count;
  logic [WIDTH-1:0] Data_Out;
  logic             Shift_Out_Msb;
  logic             Shift_Out_Lsb;
  logic             Busy;
  logic             Done;
`ifdef SHIFT_REG_XBIT_EN
  logic             X_In;
  logic             X_Load;
  logic             X_Out;
`endif

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  shift_reg_n #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .Load          (Load),
    .D             (D),
    .Mode          (Mode),
    .Shift_En      (Shift_En),
    .Shift_In_Msb  (Shift_In_Msb),
    .Shift_In_Lsb  (Shift_In_Lsb),
    .Start         (Start),
    .Count         (Count),
`ifdef SHIFT_REG_XBIT_EN
    .X_In          (X_In),
    .X_Load        (X_Load),
    .X_Out         (X_Out),
`endif
    .Data_Out      (Data_Out),
    .Shift_Out_Msb (Shift_Out_Msb),
    .Shift_Out_Lsb (Shift_Out_Lsb),
    .Busy          (Busy),
    .Done          (Done)
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check_front();
    exp_t e;
    n_checks++;
    assert (sb.size() != 0) else begin
      n_errors++;
      $error("FAIL scoreboard: observed empty queue, expected an entry");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (Data_Out === e.data && Busy === e.busy && Done === e.done) else begin
        n_errors++;
        $error("FAIL %s: observed data=%h busy=%b done=%b, expected data=%h busy=%b done=%b",
               e.tag, Data_Out, Busy, Done, e.data, e.busy, e.done);
      end
    end
  endtask

  // Queue the expectation for the coming edge, clock it, then compare.
  task automatic step(input string tag, input logic [7:0] d, input logic b, input logic dn);
    exp_t e;
    e.tag  = tag;
    e.data = d;
    e.busy = b;
    e.done = dn;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    check_front();
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic load_val(input logic [7:0] v);
    Load = 1'b1;
    D    = v;
    step("load", v, 1'b0, 1'b0);
    Load = 1'b0;
  endtask

  initial begin
    logic [7:0] e;

    Reset_n = 1'b0; Load = 1'b0; D = '0; Mode = SHR; Shift_En = 1'b0;
    Shift_In_Msb = 1'b0; Shift_In_Lsb = 1'b0; Start = 1'b0; Count = '0;
`ifdef SHIFT_REG_XBIT_EN
    X_In = 1'b0; X_Load = 1'b0;
`endif
    #2;
    step("reset", 8'h00, 1'b0, 1'b0);
    step("reset_hold", 8'h00, 1'b0, 1'b0);
    Reset_n = 1'b1;

    load_val(8'hA5);
    Reset_n = 1'b0;
    step("reset_mid_value", 8'h00, 1'b0, 1'b0);
    Reset_n = 1'b1;

`ifndef SHIFT_REG_XBIT_EN
    // Manual single shifts from A5 and 5A with Shift_In_Msb=1, Shift_In_Lsb=0.
    Shift_In_Msb = 1'b1;
    Shift_In_Lsb = 1'b0;
    load_val(8'hA5); Mode = SHR; Shift_En = 1'b1; step("a5_shr", 8'hD2, 1'b0, 1'b0); Shift_En = 1'b0;
    check_bit("shift_out_msb", Shift_Out_Msb, 1'b1);
    check_bit("shift_out_lsb", Shift_Out_Lsb, 1'b0);
    load_val(8'hA5); Mode = SHL; Shift_En = 1'b1; step("a5_shl", 8'h4A, 1'b0, 1'b0); Shift_En = 1'b0;
    load_val(8'hA5); Mode = ASR; Shift_En = 1'b1; step("a5_asr", 8'hD2, 1'b0, 1'b0); Shift_En = 1'b0;
    load_val(8'hA5); Mode = ROR; Shift_En = 1'b1; step("a5_ror", 8'hD2, 1'b0, 1'b0); Shift_En = 1'b0;
    load_val(8'h5A); Mode = SHR; Shift_En = 1'b1; step("5a_shr", 8'hAD, 1'b0, 1'b0); Shift_En = 1'b0;
    load_val(8'h5A); Mode = ASR; Shift_En = 1'b1; step("5a_asr", 8'h2D, 1'b0, 1'b0); Shift_En = 1'b0;
    load_val(8'h5A); Mode = ROR; Shift_En = 1'b1; step("5a_ror", 8'h2D, 1'b0, 1'b0); Shift_En = 1'b0;
    check_bit("shift_out_lsb_2d", Shift_Out_Lsb, 1'b1);

    // Auto ASR x3 from 81; live Mode changes during RUN must be ignored.
    load_val(8'h81);
    Start = 1'b1; Count = CNT_W'(3); Mode = ASR;
    step("asr3_start", 8'h81, 1'b1, 1'b0);
    Start = 1'b0; Mode = SHR;
    step("asr3_s1", 8'hC0, 1'b1, 1'b0);
    step("asr3_s2", 8'hE0, 1'b1, 1'b0);
    step("asr3_done", 8'hF0, 1'b0, 1'b1);
    step("asr3_idle", 8'hF0, 1'b0, 1'b0);

    // Count=0: Done next cycle, no shift, no Busy.
    Start = 1'b1; Count = '0;
    step("cnt0_done", 8'hF0, 1'b0, 1'b1);
    Start = 1'b0;
    step("cnt0_idle", 8'hF0, 1'b0, 1'b0);

    // Start held during RUN is ignored: still exactly two shifts.
    Shift_In_Msb = 1'b0; Mode = SHR;
    Start = 1'b1; Count = CNT_W'(2);
    step("run_start", 8'hF0, 1'b1, 1'b0);
    Count = CNT_W'(5);
    step("run_start_ign", 8'h78, 1'b1, 1'b0);
    Start = 1'b0;
    Shift_En = 1'b1;
    step("run2_done", 8'h3C, 1'b0, 1'b1);
    Shift_En = 1'b0;
    step("run2_idle", 8'h3C, 1'b0, 1'b0);

    // Load in the 2nd RUN cycle aborts without Done.
    load_val(8'hFF);
    Start = 1'b1; Count = CNT_W'(5);
    step("abort_start", 8'hFF, 1'b1, 1'b0);
    Start = 1'b0;
    step("abort_s1", 8'h7F, 1'b1, 1'b0);
    Load = 1'b1; D = 8'h3C;
    step("abort_load", 8'h3C, 1'b0, 1'b0);
    Load = 1'b0;
    step("abort_no_done1", 8'h3C, 1'b0, 1'b0);
    step("abort_no_done2", 8'h3C, 1'b0, 1'b0);

    // Reset mid-RUN.
    Start = 1'b1; Count = CNT_W'(5);
    step("rst_run_start", 8'h3C, 1'b1, 1'b0);
    Start = 1'b0;
    step("rst_run_s1", 8'h1E, 1'b1, 1'b0);
    Reset_n = 1'b0;
    step("rst_run", 8'h00, 1'b0, 1'b0);
    Reset_n = 1'b1;
    step("rst_run_idle", 8'h00, 1'b0, 1'b0);

    // Full-width rotate: Count=WIDTH brings the value back.
    load_val(8'hA5);
    Start = 1'b1; Count = CNT_W'(WIDTH); Mode = ROR;
    step("ror8_start", 8'hA5, 1'b1, 1'b0);
    Start = 1'b0;
    e = 8'hA5;
    for (int i = 1; i <= WIDTH; i++) begin
      e = {e[0], e[7:1]};
      step("ror8_shift", e, (i < WIDTH), (i == WIDTH));
    end
    check_bit("ror8_restored", (e == 8'hA5), 1'b1);
`else
    // X extension: ASR x8 from 00 with X=1 fills the register with ones.
    Load = 1'b1; D = 8'h00; X_Load = 1'b1; X_In = 1'b1;
    step("x_load", 8'h00, 1'b0, 1'b0);
    Load = 1'b0; X_Load = 1'b0; X_In = 1'b0;
    check_bit("x_loaded", X_Out, 1'b1);
    Start = 1'b1; Count = CNT_W'(8); Mode = ASR;
    step("x_asr_start", 8'h00, 1'b1, 1'b0);
    Start = 1'b0;
    for (int i = 1; i <= WIDTH; i++) begin
      e = ~(8'hFF >> i);
      step("x_asr_shift", e, (i < WIDTH), (i == WIDTH));
    end
    check_bit("x_asr_hold", X_Out, 1'b1);
    step("x_asr_idle", 8'hFF, 1'b0, 1'b0);

    // SHL moves the MSB into X.
    Load = 1'b1; D = 8'h80; X_Load = 1'b1; X_In = 1'b0;
    step("x_load2", 8'h80, 1'b0, 1'b0);
    Load = 1'b0; X_Load = 1'b0;
    check_bit("x_cleared", X_Out, 1'b0);
    Mode = SHL; Shift_In_Lsb = 1'b1; Shift_En = 1'b1;
    step("x_shl", 8'h01, 1'b0, 1'b0);
    Shift_En = 1'b0;
    check_bit("x_shl_msb_in", X_Out, 1'b1);

    // ROR: X into MSB, LSB into X.
    Mode = ROR; Shift_En = 1'b1;
    step("x_ror", 8'h80, 1'b0, 1'b0);
    Shift_En = 1'b0;
    check_bit("x_ror_lsb_in", X_Out, 1'b1);

    // SHR: X into MSB, Shift_In_Msb into X.
    Mode = SHR; Shift_In_Msb = 1'b0; Shift_En = 1'b1;
    step("x_shr", 8'hC0, 1'b0, 1'b0);
    Shift_En = 1'b0;
    check_bit("x_shr_in", X_Out, 1'b0);

    Reset_n = 1'b0;
    step("x_reset", 8'h00, 1'b0, 1'b0);
    Reset_n = 1'b1;
    check_bit("x_reset_val", X_Out, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
